// File: rtl/dffen_bank_pkg.sv
// Shared types and the per-channel update rule for the enabled register bank.
package dffen_bank_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    // Works on a MAX_W-wide container; callers keep only their low WIDTH bits.
    function automatic logic [MAX_W-1:0] next_val(op_e op, logic [MAX_W-1:0] cur,
                                                  logic [MAX_W-1:0] d);
        logic [MAX_W-1:0] r;
        r = cur;
        case (op)
            OP_LOAD: r = d;
            OP_SET:  r = '1;
            OP_CLR:  r = '0;
            OP_TGL:  r = ~cur;
            default: r = cur;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dffen_bank_if.sv
// Control and status bus of the enabled register bank.
interface dffen_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 1,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0]            en;
    logic [NUM_CH-1:0][1:0]       mode;
    logic [NUM_CH-1:0][WIDTH-1:0] di;
    logic                         commit;
    logic [NUM_CH-1:0]            chg_clr;
    logic [NUM_CH-1:0][WIDTH-1:0] shadow;
    logic [NUM_CH-1:0][WIDTH-1:0] q;
    logic [NUM_CH-1:0]            chg;
    logic [CNT_W-1:0]             commit_cnt;

    modport master (
        output en, mode, di, commit, chg_clr,
        input  shadow, q, chg, commit_cnt
    );

    modport slave (
        input  en, mode, di, commit, chg_clr,
        output shadow, q, chg, commit_cnt
    );
endinterface

// File: rtl/dffen_chan.sv
// One channel: shadow register, committed (or pass-through) output and sticky change flag.
module dffen_chan
    import dffen_bank_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit DOUBLE_BUF = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  op_e              op,
    input  logic [WIDTH-1:0] di,
    input  logic             commit,
    input  logic             chg_clr,
    output logic [WIDTH-1:0] shadow,
    output logic [WIDTH-1:0] q,
    output logic             chg
);
    logic [MAX_W-1:0] calc;
    logic [WIDTH-1:0] sh_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             unused_calc;

    always_comb begin
        calc   = next_val(op, MAX_W'(shadow), MAX_W'(di));
        sh_nxt = en ? calc[WIDTH-1:0] : shadow;
    end
    assign unused_calc = ^calc;

    always_ff @(posedge clk) begin
        if (rst) shadow <= '0;
        else     shadow <= sh_nxt;
    end

    generate
        if (DOUBLE_BUF) begin : g_dbuf
            logic [WIDTH-1:0] q_r;
            // Commit captures the pre-edge shadow, so a same-cycle write waits for the next commit.
            assign q_nxt = commit ? shadow : q_r;
            always_ff @(posedge clk) begin
                if (rst) q_r <= '0;
                else     q_r <= q_nxt;
            end
            assign q = q_r;
        end else begin : g_thru
            logic unused_commit;
            assign unused_commit = commit;
            assign q_nxt = sh_nxt;
            assign q     = shadow;
        end
    endgenerate

    // A real value change beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) chg <= 1'b0;
        else     chg <= (q_nxt != q) | (chg & ~chg_clr);
    end

endmodule

// File: rtl/dffen_bank.sv
// Bank of NUM_CH enabled register channels with optional double buffering and commit counter.
module dffen_bank
    import dffen_bank_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 1,
    parameter bit DOUBLE_BUF = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    dffen_bank_if.slave  bus
);
    logic [NUM_CH-1:0][WIDTH-1:0] sh_v;
    logic [NUM_CH-1:0][WIDTH-1:0] q_v;
    logic [NUM_CH-1:0]            chg_v;
    logic [CNT_W-1:0]             cnt;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            dffen_chan #(
                .WIDTH      (WIDTH),
                .DOUBLE_BUF (DOUBLE_BUF)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .en      (bus.en[c]),
                .op      (op_e'(bus.mode[c])),
                .di      (bus.di[c]),
                .commit  (bus.commit),
                .chg_clr (bus.chg_clr[c]),
                .shadow  (sh_v[c]),
                .q       (q_v[c]),
                .chg     (chg_v[c])
            );
        end
    endgenerate

    // Counts commits in both buffering modes; wraps naturally at CNT_W bits.
    always_ff @(posedge clk) begin
        if (rst)             cnt <= '0;
        else if (bus.commit) cnt <= cnt + 1'b1;
    end

    assign bus.shadow     = sh_v;
    assign bus.q          = q_v;
    assign bus.chg        = chg_v;
    assign bus.commit_cnt = cnt;

endmodule

// File: tb/tb_dffen_bank.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_dffen_bank;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dffen_bank_if #(.NUM_CH(4), .WIDTH(1), .CNT_W(2)) ia ();
    dffen_bank_if #(.NUM_CH(4), .WIDTH(4), .CNT_W(3)) ib ();
    dffen_bank_if #(.NUM_CH(3), .WIDTH(5), .CNT_W(4)) ic ();

    dffen_bank #(.NUM_CH(4), .WIDTH(1), .DOUBLE_BUF(1'b1), .CNT_W(2))
        u_a (.clk(clk), .rst(rst_a), .bus(ia.slave));
    dffen_bank #(.NUM_CH(4), .WIDTH(4), .DOUBLE_BUF(1'b0), .CNT_W(3))
        u_b (.clk(clk), .rst(rst_b), .bus(ib.slave));
    dffen_bank #(.NUM_CH(3), .WIDTH(5), .DOUBLE_BUF(1'b1), .CNT_W(4))
        u_c (.clk(clk), .rst(rst_c), .bus(ic.slave));

    // Behavioural model: per-channel integers, one array row per instance.
    int m_sh [3][8];
    int m_q  [3][8];
    bit m_chg[3][8];
    int m_cnt[3];

    function automatic void model_step(int k, int nch, int w, bit db, int cntw, logic r,
                                       logic [7:0] en, logic [15:0] mode, logic [39:0] di,
                                       logic cm, logic [7:0] clr);
        int mask, nsh, nq;
        mask = (1 << w) - 1;
        if (r) begin
            for (int c = 0; c < 8; c++) begin
                m_sh[k][c] = 0; m_q[k][c] = 0; m_chg[k][c] = 1'b0;
            end
            m_cnt[k] = 0;
            return;
        end
        for (int c = 0; c < nch; c++) begin
            nsh = m_sh[k][c];
            if (en[c]) begin
                case (mode[2*c +: 2])
                    2'd0: nsh = int'(di >> (c * w)) & mask;
                    2'd1: nsh = mask;
                    2'd2: nsh = 0;
                    default: nsh = ~nsh & mask;
                endcase
            end
            nq = db ? (cm ? m_sh[k][c] : m_q[k][c]) : nsh;
            if (nq != m_q[k][c]) m_chg[k][c] = 1'b1;
            else if (clr[c])     m_chg[k][c] = 1'b0;
            m_sh[k][c] = nsh;
            m_q[k][c]  = nq;
        end
        if (cm) m_cnt[k] = (m_cnt[k] + 1) % (1 << cntw);
    endfunction

    function automatic logic [39:0] pack_val(int k, int nch, int w, bit use_q);
        logic [39:0] r;
        r = '0;
        for (int c = 0; c < nch; c++)
            r = r | (40'(use_q ? m_q[k][c] : m_sh[k][c]) << (c * w));
        return r;
    endfunction

    function automatic logic [7:0] pack_chg(int k, int nch);
        logic [7:0] r;
        r = '0;
        for (int c = 0; c < nch; c++) r[c] = m_chg[k][c];
        return r;
    endfunction

    always @(posedge clk) begin
        model_step(0, 4, 1, 1'b1, 2, rst_a, 8'(ia.en), 16'(ia.mode), 40'(ia.di), ia.commit, 8'(ia.chg_clr));
        model_step(1, 4, 4, 1'b0, 3, rst_b, 8'(ib.en), 16'(ib.mode), 40'(ib.di), ib.commit, 8'(ib.chg_clr));
        model_step(2, 3, 5, 1'b1, 4, rst_c, 8'(ic.en), 16'(ic.mode), 40'(ic.di), ic.commit, 8'(ic.chg_clr));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_all();
        ia.en = '0; ia.mode = '0; ia.di = '0; ia.commit = 1'b0; ia.chg_clr = '0;
        ib.en = '0; ib.mode = '0; ib.di = '0; ib.commit = 1'b0; ib.chg_clr = '0;
        ic.en = '0; ic.mode = '0; ic.di = '0; ic.commit = 1'b0; ic.chg_clr = '0;
    endtask

    task automatic test_reset();
        ia.en = 4'b1111; ia.mode = 8'b0101_0101;
        ib.en = 4'b1111; ib.mode = 8'b0101_0101;
        ic.en = 3'b111;  ic.mode = 6'b01_0101; ic.commit = 1'b1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (2) tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        idle_all();
        checks++; if (ia.shadow !== 4'b0000) begin errors++; $display("FAIL reset_shadow_a got=%b exp=0000", ia.shadow); end
        checks++; if (ia.q !== 4'b0000) begin errors++; $display("FAIL reset_q_a got=%b exp=0000", ia.q); end
        checks++; if (ia.chg !== 4'b0000) begin errors++; $display("FAIL reset_chg_a got=%b exp=0000", ia.chg); end
        checks++; if (ia.commit_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt_a got=%0d exp=0", ia.commit_cnt); end
        checks++; if (ib.q !== 16'h0000) begin errors++; $display("FAIL reset_q_b got=%h exp=0000", ib.q); end
        checks++; if ({ic.q, ic.shadow, ic.commit_cnt} !== '0) begin errors++; $display("FAIL reset_c got q=%h sh=%h cnt=%0d exp all zero", ic.q, ic.shadow, ic.commit_cnt); end
    endtask

    task automatic test_load_commit();
        ia.en = 4'b0101; ia.mode = 8'h00; ia.di = 4'b1111;
        tick();
        checks++; if (ia.shadow !== 4'b0101) begin errors++; $display("FAIL load_shadow got=%b exp=0101", ia.shadow); end
        checks++; if (ia.q !== 4'b0000) begin errors++; $display("FAIL load_q_hold got=%b exp=0000", ia.q); end
        ia.en = '0; ia.commit = 1'b1;
        tick();
        ia.commit = 1'b0;
        checks++; if (ia.q !== 4'b0101) begin errors++; $display("FAIL commit_q got=%b exp=0101", ia.q); end
        checks++; if (ia.chg !== 4'b0101) begin errors++; $display("FAIL commit_chg got=%b exp=0101", ia.chg); end
        checks++; if (ia.commit_cnt !== 2'd1) begin errors++; $display("FAIL commit_cnt got=%0d exp=1", ia.commit_cnt); end
    endtask

    task automatic test_write_commit();
        ia.en = 4'b1111; ia.mode = 8'hFF; ia.commit = 1'b1;
        tick();
        checks++; if (ia.q !== 4'b0101) begin errors++; $display("FAIL wc_q got=%b exp=0101", ia.q); end
        checks++; if (ia.shadow !== 4'b1010) begin errors++; $display("FAIL wc_shadow got=%b exp=1010", ia.shadow); end
        ia.en = '0; ia.mode = '0;
        tick();
        ia.commit = 1'b0;
        checks++; if (ia.q !== 4'b1010) begin errors++; $display("FAIL wc_q2 got=%b exp=1010", ia.q); end
        checks++; if (ia.chg !== 4'b1111) begin errors++; $display("FAIL wc_chg got=%b exp=1111", ia.chg); end
        checks++; if (ia.commit_cnt !== 2'd3) begin errors++; $display("FAIL wc_cnt got=%0d exp=3", ia.commit_cnt); end
    endtask

    task automatic test_chg_priority();
        ia.chg_clr = 4'b1111; tick(); ia.chg_clr = '0;
        checks++; if (ia.chg !== 4'b0000) begin errors++; $display("FAIL clr_all got=%b exp=0000", ia.chg); end
        ia.en = 4'b0001; ia.mode = 8'b0000_0001; tick();
        ia.en = '0; ia.commit = 1'b1; tick(); ia.commit = 1'b0;
        checks++; if (ia.chg !== 4'b0001) begin errors++; $display("FAIL chg_set got=%b exp=0001", ia.chg); end
        checks++; if (ia.commit_cnt !== 2'd0) begin errors++; $display("FAIL cnt_wrap1 got=%0d exp=0", ia.commit_cnt); end
        ia.en = 4'b0001; ia.mode = 8'b0000_0010; tick();
        ia.en = '0; ia.commit = 1'b1; ia.chg_clr = 4'b0001; tick();
        ia.commit = 1'b0;
        checks++; if ({ia.q, ia.chg} !== {4'b1010, 4'b0001}) begin errors++; $display("FAIL set_beats_clr got q=%b chg=%b exp q=1010 chg=0001", ia.q, ia.chg); end
        tick(); ia.chg_clr = '0;
        checks++; if (ia.chg !== 4'b0000) begin errors++; $display("FAIL clr_alone got=%b exp=0000", ia.chg); end
        ia.commit = 1'b1; tick(); ia.commit = 1'b0;
        checks++; if (ia.chg !== 4'b0000) begin errors++; $display("FAIL same_value got=%b exp=0000", ia.chg); end
        checks++; if (ia.commit_cnt !== 2'd2) begin errors++; $display("FAIL cnt_after got=%0d exp=2", ia.commit_cnt); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        ia.commit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ia.commit_cnt !== exp_seq[i]) begin errors++; $display("FAIL wrap_%0d got=%0d exp=%0d", i, ia.commit_cnt, exp_seq[i]); end
        end
        ia.commit = 1'b0;
    endtask

    task automatic test_passthru();
        ib.en = 4'b0100; ib.mode = 8'h00; ib.di = 16'h0A00; ib.commit = 1'b1;
        tick();
        ib.commit = 1'b0;
        checks++; if (ib.q !== 16'h0A00) begin errors++; $display("FAIL pt_load_q got=%h exp=0a00", ib.q); end
        checks++; if (ib.shadow !== 16'h0A00) begin errors++; $display("FAIL pt_load_sh got=%h exp=0a00", ib.shadow); end
        checks++; if (ib.commit_cnt !== 3'd1) begin errors++; $display("FAIL pt_cnt got=%0d exp=1", ib.commit_cnt); end
        ib.mode = 8'b0001_0000;
        tick();
        checks++; if (ib.q !== 16'h0F00) begin errors++; $display("FAIL pt_set_q got=%h exp=0f00", ib.q); end
        checks++; if (ib.chg !== 4'b0100) begin errors++; $display("FAIL pt_chg got=%b exp=0100", ib.chg); end
        ib.en = 4'b1111; ib.mode = 8'hFF; ib.commit = 1'b1; rst_b = 1'b1;
        tick();
        rst_b = 1'b0; ib.en = '0; ib.mode = '0; ib.commit = 1'b0;
        checks++; if ({ib.q, ib.chg, ib.commit_cnt} !== '0) begin errors++; $display("FAIL pt_reset got q=%h chg=%b cnt=%0d exp all zero", ib.q, ib.chg, ib.commit_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_a = ($urandom_range(0, 39) == 0); rst_b = ($urandom_range(0, 39) == 0);
            rst_c = ($urandom_range(0, 39) == 0);
            ia.en = 4'($urandom); ia.mode = 8'($urandom); ia.di = 4'($urandom);
            ia.commit = 1'($urandom); ia.chg_clr = 4'($urandom);
            ib.en = 4'($urandom); ib.mode = 8'($urandom); ib.di = 16'($urandom);
            ib.commit = 1'($urandom); ib.chg_clr = 4'($urandom);
            ic.en = 3'($urandom); ic.mode = 6'($urandom); ic.di = 15'($urandom);
            ic.commit = 1'($urandom); ic.chg_clr = 3'($urandom);
            tick();
            checks++; if ({ia.shadow, ia.q, ia.chg, ia.commit_cnt} !== {pack_val(0,4,1,0)[3:0], pack_val(0,4,1,1)[3:0], pack_chg(0,4)[3:0], 2'(m_cnt[0])})
                begin errors++; $display("FAIL rand_a cyc=%0d got sh=%b q=%b chg=%b cnt=%0d exp sh=%b q=%b chg=%b cnt=%0d", i, ia.shadow, ia.q, ia.chg, ia.commit_cnt, pack_val(0,4,1,0)[3:0], pack_val(0,4,1,1)[3:0], pack_chg(0,4)[3:0], m_cnt[0]); end
            checks++; if ({ib.shadow, ib.q, ib.chg, ib.commit_cnt} !== {pack_val(1,4,4,0)[15:0], pack_val(1,4,4,1)[15:0], pack_chg(1,4)[3:0], 3'(m_cnt[1])})
                begin errors++; $display("FAIL rand_b cyc=%0d got sh=%h q=%h chg=%b cnt=%0d exp sh=%h q=%h chg=%b cnt=%0d", i, ib.shadow, ib.q, ib.chg, ib.commit_cnt, pack_val(1,4,4,0)[15:0], pack_val(1,4,4,1)[15:0], pack_chg(1,4)[3:0], m_cnt[1]); end
            checks++; if ({ic.shadow, ic.q, ic.chg, ic.commit_cnt} !== {pack_val(2,3,5,0)[14:0], pack_val(2,3,5,1)[14:0], pack_chg(2,3)[2:0], 4'(m_cnt[2])})
                begin errors++; $display("FAIL rand_c cyc=%0d got sh=%h q=%h chg=%b cnt=%0d exp sh=%h q=%h chg=%b cnt=%0d", i, ic.shadow, ic.q, ic.chg, ic.commit_cnt, pack_val(2,3,5,0)[14:0], pack_val(2,3,5,1)[14:0], pack_chg(2,3)[2:0], m_cnt[2]); end
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        idle_all();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        idle_all();
        test_reset();
        test_load_commit();
        test_write_commit();
        test_chg_priority();
        test_wrap();
        test_passthru();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
